plab5_mcore_proc_req_acc: RTL and testbench
===========================================

PLAB5_MCORE_PROC_REQ_ACC -- requirements
Module: plab5_mcore_proc_req_acc

Interface
REQ-001 SHALL have parameter p_opaque_nbits, default 8, memory message opaque field width (o).
REQ-002 SHALL have parameter p_addr_nbits, default 32, memory message address width (a).
REQ-003 SHALL have parameter p_data_nbits, default 32, memory message data width (d).
REQ-004 SHALL have parameter p_sec_addr_base, default 32'h0000_8000; addresses >= base are in the high (level 1) region, addresses below it are in the low (level 0) region.
REQ-005 SHALL have one clock, clk (input, 1), with all state updated on its rising edge.
REQ-006 SHALL have reset (input, 1), asynchronous and active-low: 0 resets immediately, independent of clk.
REQ-007 proc_sec_level  input  1  security level of the issuing processor.
REQ-008 proc_req_val/proc_req_rdy/proc_req_msg  input/output/input  1/1/VC_MEM_REQ_MSG_NBITS(o,a,d)  request from the processor.
REQ-009 net_req_val/net_req_rdy/net_req_msg  output/input/output  1/1/VC_MEM_REQ_MSG_NBITS(o,a,d)  permitted request to the network.
REQ-010 net_req_sec_level  output  1  security level tagged on net_req_msg.
REQ-011 deny_resp_val/deny_resp_rdy/deny_resp_msg  output/input/output  1/1/VC_MEM_RESP_MSG_NBITS(o,d)  locally generated denial response to the processor.
REQ-012 deny_count  output  8  count of denied requests.

Function
REQ-013 SHALL hold exactly one request in a buffer register, with state EMPTY, FWD or DENY.
REQ-014 Policy: at acceptance, region_level = (addr >= p_sec_addr_base). The request SHALL be permitted iff region_level <= proc_sec_level, and denied otherwise.
REQ-015 proc_req_rdy SHALL be 1 when the state is EMPTY, or when the held item completes its output handshake in the same cycle (pass-through, 1 request per cycle sustained).
REQ-016 On a proc_req_val && proc_req_rdy handshake, the block SHALL latch the message and proc_sec_level, then enter FWD if permitted or DENY if denied.
REQ-017 Latency SHALL be exactly 1 cycle: a request accepted on edge N is presented on its output from edge N onward, i.e. valid in cycle N+1. There SHALL be no combinational path from proc_req_val to any output valid.
REQ-018 In FWD: net_req_val=1, net_req_msg = latched message unmodified, net_req_sec_level = latched level. deny_resp_val=0.
REQ-019 In DENY: deny_resp_val=1, net_req_val=0. deny_resp_msg type = latched request type, opaque = latched opaque, len = 0, data = all ones.
REQ-020 When EMPTY, net_req_val=0 and deny_resp_val=0. net_req_msg, net_req_sec_level and deny_resp_msg SHALL be driven from the buffer regardless of state (don't-care when invalid).
REQ-021 The output payload and valid SHALL remain stable while the valid is high and the matching rdy is low.
REQ-022 When the held item's handshake fires and no new request is accepted, the state SHALL return to EMPTY. If a new request is accepted in the same cycle, the state SHALL go directly to its FWD/DENY state.
REQ-023 A change of proc_sec_level while a request is held SHALL NOT affect that request's classification or tag.
REQ-024 deny_count SHALL increment by 1 on each denied request accepted, and SHALL saturate at 255 with no wrap.
REQ-025 A permitted request SHALL never appear on deny_resp, and a denied request SHALL never appear on net_req.

Reset
REQ-026 While reset=0: state=EMPTY, net_req_val=0, deny_resp_val=0, proc_req_rdy=0, deny_count=0, buffer contents don't-care.
REQ-027 Reset asserted mid-operation SHALL discard the held request, which is then never emitted. After release, proc_req_rdy SHALL be 1 in the first cycle.

Verification
REQ-028 Level 0 read of addr 0x100, net_req_rdy=1 -> net_req_val=1 the next cycle with an identical msg and net_req_sec_level=0; deny_resp_val stays 0.
REQ-029 Level 0 write of addr 0x8000 (opaque 0x5A) -> deny_resp_val=1 the next cycle, msg type=write, opaque=0x5A, len=0, data=0xFFFFFFFF; net_req_val stays 0; deny_count=1.
REQ-030 Level 1 read of addr 0x8000 with net_req_rdy=0 for 3 cycles -> net_req_val held at 1 with a stable msg, proc_req_rdy=0; after rdy=1, back-to-back requests stream at 1 per cycle.
REQ-031 Denied request held with deny_resp_rdy=0 while proc_sec_level toggles to 1 -> still delivered as a denial; no net_req emitted.
REQ-032 300 denied requests -> deny_count reads 255 and stays there.
REQ-033 reset=0 asynchronously while in FWD -> net_req_val drops to 0 without a clock edge; after release, the held request is never emitted and deny_count=0.

Source files
------------

// File: rtl/plab5_mcore_proc_req_acc.sv
// -----------------------------------------------------------------------------
// plab5_mcore_proc_req_acc
//
// Security access checker between a processor's memory request port and the
// memory network. Each incoming request is classified against a single
// address boundary:
//   region_level = (addr >= p_sec_addr_base)
//   permitted    = (region_level <= proc_sec_level)
// A permitted request is forwarded unmodified to the network together with
// the issuer's security level. A denied request never reaches the network.
// Instead it is answered locally with a response of the same type and opaque,
// len = 0 and data = all ones.
//
// A single buffer register holds one request. Its FSM state is EMPTY, FWD or
// DENY. Latency is one cycle. The buffer also passes requests through: a new
// request can be accepted in the same cycle that the held one leaves, which
// sustains one request per cycle.
//
// Message layouts (MSB first):
//   request  : { type[2:0], opaque[o-1:0], addr[a-1:0], len[l-1:0], data[d-1:0] }
//   response : { type[2:0], opaque[o-1:0], len[l-1:0], data[d-1:0] }
//   where l = $clog2(d/8).
//
// Handshake rule for every val/rdy pair in this block: a transfer happens in
// any cycle where val && rdy at the rising edge of clk. A producer that raises
// val keeps val and its payload stable until that transfer. No output val is
// derived combinationally from an input val.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   proc_sec_level      security level of the issuing processor
//   proc_req_*          request stream from the processor (val/rdy/msg)
//   net_req_*           permitted requests to the network (val/rdy/msg)
//   net_req_sec_level   security level latched with the forwarded request
//   deny_resp_*         locally generated denial responses (val/rdy/msg)
//   deny_count          saturating count of denied requests (max 255)
//   dbg_state           current FSM state (EMPTY=0, FWD=1, DENY=2)
// -----------------------------------------------------------------------------
module plab5_mcore_proc_req_acc #(
  parameter int          p_opaque_nbits  = 8,
  parameter int          p_addr_nbits    = 32,
  parameter int          p_data_nbits    = 32,
  parameter logic [31:0] p_sec_addr_base = 32'h0000_8000,
  localparam int         c_len_nbits     = $clog2(p_data_nbits / 8),
  localparam int         c_req_nbits     = 3 + p_opaque_nbits + p_addr_nbits
                                           + c_len_nbits + p_data_nbits,
  localparam int         c_resp_nbits    = 3 + p_opaque_nbits + c_len_nbits
                                           + p_data_nbits
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    proc_sec_level,

  input  logic                    proc_req_val,
  output logic                    proc_req_rdy,
  input  logic [c_req_nbits-1:0]  proc_req_msg,

  output logic                    net_req_val,
  input  logic                    net_req_rdy,
  output logic [c_req_nbits-1:0]  net_req_msg,
  output logic                    net_req_sec_level,

  output logic                    deny_resp_val,
  input  logic                    deny_resp_rdy,
  output logic [c_resp_nbits-1:0] deny_resp_msg,

  output logic [7:0]              deny_count,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] st_empty = 2'd0;
  localparam logic [1:0] st_fwd   = 2'd1;
  localparam logic [1:0] st_deny  = 2'd2;

  // Bit offsets of the request fields.
  localparam int c_addr_lsb   = p_data_nbits + c_len_nbits;
  localparam int c_opaque_lsb = c_addr_lsb + p_addr_nbits;
  localparam int c_type_lsb   = c_opaque_lsb + p_opaque_nbits;

  localparam logic [p_addr_nbits-1:0] c_sec_base = p_addr_nbits'(p_sec_addr_base);

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [c_req_nbits-1:0] buf_msg;
  logic                   buf_level;

  logic                    out_fire;
  logic                    accept;
  logic                    region_level;
  logic                    permit;
  logic [p_addr_nbits-1:0] req_addr;

  // ---------------------------------------------------------------------------
  // Handshake and classification
  // ---------------------------------------------------------------------------

  // The held item leaves when the handshake on its own output port fires.
  assign out_fire = ((state == st_fwd)  && net_req_rdy) ||
                    ((state == st_deny) && deny_resp_rdy);

  // Pass-through: the slot counts as free when the held item leaves this
  // cycle. rst_n gates rdy so that no request is taken while reset is held.
  assign proc_req_rdy = rst_n && ((state == st_empty) || out_fire);
  assign accept       = proc_req_val && proc_req_rdy;

  assign req_addr     = proc_req_msg[c_addr_lsb +: p_addr_nbits];
  assign region_level = (req_addr >= c_sec_base);
  assign permit       = !region_level || proc_sec_level;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = permit ? st_fwd : st_deny;
    end else if (out_fire) begin
      state_next = st_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= st_empty;
    end else begin
      state <= state_next;
    end
  end

  // Payload and level are don't-care while EMPTY, so they need no reset.
  // The level is latched here so that later changes of proc_sec_level
  // do not retag a request that is already held.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_msg   <= proc_req_msg;
      buf_level <= proc_sec_level;
    end
  end

  // ---------------------------------------------------------------------------
  // Denial counter, saturating at 255
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_count <= 8'd0;
    end else if (accept && !permit && (deny_count != 8'hFF)) begin
      deny_count <= deny_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign net_req_val       = (state == st_fwd);
  assign deny_resp_val     = (state == st_deny);
  assign net_req_msg       = buf_msg;
  assign net_req_sec_level = buf_level;

  assign deny_resp_msg = { buf_msg[c_type_lsb +: 3],
                           buf_msg[c_opaque_lsb +: p_opaque_nbits],
                           {c_len_nbits{1'b0}},
                           {p_data_nbits{1'b1}} };

  assign dbg_state = state;

endmodule

// File: tb/tb_plab5_mcore_proc_req_acc.sv
// -----------------------------------------------------------------------------
// Testbench for plab5_mcore_proc_req_acc (default parameters: o=8, a=32, d=32).
// Inputs change on the falling edge and outputs are checked 1 time unit later.
// The reference model keeps the pending requests in exp_q as {permit, level,
// msg}. The rdy, valid and payload values it expects come from the access
// rules, not from the DUT's state machine.
// -----------------------------------------------------------------------------
module tb_plab5_mcore_proc_req_acc;

  localparam int REQ_W  = 77;
  localparam int RESP_W = 45;
  localparam logic [31:0] BASE = 32'h0000_8000;

  logic              clk;
  logic              rst_n;
  logic              proc_sec_level;
  logic              proc_req_val;
  logic              proc_req_rdy;
  logic [REQ_W-1:0]  proc_req_msg;
  logic              net_req_val;
  logic              net_req_rdy;
  logic [REQ_W-1:0]  net_req_msg;
  logic              net_req_sec_level;
  logic              deny_resp_val;
  logic              deny_resp_rdy;
  logic [RESP_W-1:0] deny_resp_msg;
  logic [7:0]        deny_count;
  logic [1:0]        dbg_state;

  plab5_mcore_proc_req_acc dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .proc_sec_level    (proc_sec_level),
    .proc_req_val      (proc_req_val),
    .proc_req_rdy      (proc_req_rdy),
    .proc_req_msg      (proc_req_msg),
    .net_req_val       (net_req_val),
    .net_req_rdy       (net_req_rdy),
    .net_req_msg       (net_req_msg),
    .net_req_sec_level (net_req_sec_level),
    .deny_resp_val     (deny_resp_val),
    .deny_resp_rdy     (deny_resp_rdy),
    .deny_resp_msg     (deny_resp_msg),
    .deny_count        (deny_count),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [REQ_W+1:0] exp_q[$];   // {permit, level, msg}
  int               exp_dcnt;
  int               n_vec;
  int               n_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] typ, input logic [7:0] op,
                                              input logic [31:0] addr, input logic [1:0] len,
                                              input logic [31:0] data);
    return {typ, op, addr, len, data};
  endfunction

  function automatic logic [REQ_W-1:0] rand_req();
    logic [31:0] a;
    if ($urandom_range(0, 1) == 1) a = $urandom_range(32'h7FF0, 32'h8010);
    else                           a = $urandom;
    return mk_req(3'($urandom_range(0, 1)), 8'($urandom), a, 2'($urandom_range(0, 3)), $urandom);
  endfunction

  // One cycle: drive inputs at the falling edge, check outputs, update the
  // model with what the coming rising edge does, then advance to the next
  // falling edge.
  task automatic step(input logic pv, input logic [REQ_W-1:0] pm, input logic lvl,
                      input logic nrdy, input logic drdy);
    logic             held, perm_h, out_fire, exp_rdy, perm_new;
    logic [REQ_W+1:0] h;
    logic [REQ_W-1:0] hm;
    proc_req_val   = pv;
    proc_req_msg   = pm;
    proc_sec_level = lvl;
    net_req_rdy    = nrdy;
    deny_resp_rdy  = drdy;
    #1;
    held   = (exp_q.size() != 0);
    h      = held ? exp_q[0] : '0;
    perm_h = h[REQ_W+1];
    hm     = h[REQ_W-1:0];
    out_fire = held && (perm_h ? nrdy : drdy);
    exp_rdy  = !held || out_fire;
    check("net_req_val",   128'(net_req_val),   128'(held && perm_h));
    check("deny_resp_val", 128'(deny_resp_val), 128'(held && !perm_h));
    check("proc_req_rdy",  128'(proc_req_rdy),  128'(exp_rdy));
    check("deny_count",    128'(deny_count),    128'(exp_dcnt));
    if (held && perm_h) begin
      check("net_req_msg",       128'(net_req_msg),       128'(hm));
      check("net_req_sec_level", 128'(net_req_sec_level), 128'(h[REQ_W]));
    end
    if (held && !perm_h) begin
      // The denial response keeps type and opaque, with len = 0 and data all ones.
      check("deny_resp_msg", 128'(deny_resp_msg),
            128'({hm[76:74], hm[73:66], 2'b00, 32'hFFFF_FFFF}));
    end
    if (out_fire) void'(exp_q.pop_front());
    if (pv && exp_rdy) begin
      perm_new = !(pm[65:34] >= BASE) || lvl;
      exp_q.push_back({perm_new, lvl, pm});
      if (!perm_new && exp_dcnt < 255) exp_dcnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic nrdy, input logic drdy);
    step(1'b0, rand_req(), 1'($urandom_range(0, 1)), nrdy, drdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0; exp_dcnt = 0;
    rst_n = 1'b0; proc_req_val = 1'b0; proc_req_msg = '0; proc_sec_level = 1'b0;
    net_req_rdy = 1'b0; deny_resp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy",   128'(proc_req_rdy),  128'(0));
    check("reset_nval",  128'(net_req_val),   128'(0));
    check("reset_dval",  128'(deny_resp_val), 128'(0));
    check("reset_dcnt",  128'(deny_count),    128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Level 0 read below the boundary is forwarded.
    step(1'b1, mk_req(3'd0, 8'h11, 32'h100, 2'd0, 32'h0), 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // Level 0 write at the boundary is denied.
    step(1'b1, mk_req(3'd1, 8'h5A, 32'h8000, 2'd0, 32'hCAFE_F00D), 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // Level 1 read at the boundary is held under backpressure, then streams.
    step(1'b1, mk_req(3'd0, 8'h22, 32'h8000, 2'd0, 32'h0), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, mk_req(3'd0, 8'h33, 32'h10, 2'd0, 32'h0), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b1, mk_req(3'd0, 8'(8'h40 + i), 32'h8000 + 32'(i), 2'd0, 32'h0), 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // A held denial is unaffected when proc_sec_level changes.
    step(1'b1, mk_req(3'd1, 8'h77, 32'hFFFF_0000, 2'd3, 32'h1234), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // Denials saturate the counter at 255.
    for (int i = 0; i < 300; i++)
      step(1'b1, mk_req(3'd0, 8'(i), 32'h9000, 2'd0, 32'h0), 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    check("dcnt_sat", 128'(deny_count), 128'(255));

    // Asynchronous reset while a request sits in FWD.
    step(1'b1, mk_req(3'd0, 8'h99, 32'h200, 2'd0, 32'h0), 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_nval", 128'(net_req_val),  128'(0));
    check("async_dcnt", 128'(deny_count),   128'(0));
    check("async_rdy",  128'(proc_req_rdy), 128'(0));
    exp_q.delete();
    exp_dcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), rand_req(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
